// File: rtl/proxy_remap_ctrl.sv
// BISR spare allocator: takes one BIST fault map per handshake and scans it one lane per cycle.
// It then commits every per-lane mux select to the spare-proxy muxes on a single clock edge.
module proxy_remap_ctrl #(
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned NUM_SPARES = 2,
   localparam int unsigned SEL_W     = $clog2(NUM_SPARES + 1),
   localparam int unsigned CNT_W     = $clog2(NUM_SPARES + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        fault_valid,
   output logic                        fault_ready,
   input  logic [NUM_LANES-1:0]        fault_map,
   input  logic                        clear,
   output logic [NUM_LANES*SEL_W-1:0]  sel_bus,
   output logic                        remap_done,
   output logic                        remap_fail,
   output logic [CNT_W-1:0]            spares_used
);

   localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(NUM_SPARES);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StScan   = 2'd1,
      StCommit = 2'd2
   } state_e;

   state_e                             state_q, state_d;
   logic [NUM_LANES-1:0]               map_q, map_d;
   logic [IDX_W-1:0]                   lane_q, lane_d;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;
   logic                               flag_q, flag_d;
   logic [NUM_LANES-1:0][SEL_W-1:0]    shadow_q, shadow_d;
   logic [NUM_LANES*SEL_W-1:0]         sel_bus_q, sel_bus_d;
   logic [CNT_W-1:0]                   used_q, used_d;
   logic                               fail_q, fail_d;
   logic                               done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         map_q     <= '0;
         lane_q    <= '0;
         cnt_q     <= '0;
         flag_q    <= 1'b0;
         shadow_q  <= '0;
         sel_bus_q <= '0;
         used_q    <= '0;
         fail_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         map_q     <= map_d;
         lane_q    <= lane_d;
         cnt_q     <= cnt_d;
         flag_q    <= flag_d;
         shadow_q  <= shadow_d;
         sel_bus_q <= sel_bus_d;
         used_q    <= used_d;
         fail_q    <= fail_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      map_d     = map_q;
      lane_d    = lane_q;
      cnt_d     = cnt_q;
      flag_d    = flag_q;
      shadow_d  = shadow_q;
      sel_bus_d = sel_bus_q;
      used_d    = used_q;
      fail_d    = fail_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A handshake takes priority over clear on the same edge.
            if (fault_valid) begin
               map_d    = fault_map;
               shadow_d = '0;
               lane_d   = '0;
               cnt_d    = '0;
               flag_d   = 1'b0;
               fail_d   = 1'b0;
               state_d  = StScan;
            end else if (clear) begin
               sel_bus_d = '0;
               used_d    = '0;
            end
         end

         StScan: begin
            if (map_q[lane_q]) begin
               if (cnt_q < MAX_CNT) begin
                  shadow_d[lane_q] = SEL_W'(cnt_q + CNT_W'(1));
                  cnt_d            = cnt_q + CNT_W'(1);
               end else begin
                  shadow_d[lane_q] = '0;
                  flag_d           = 1'b1;
               end
            end else begin
               shadow_d[lane_q] = '0;
            end
            if (lane_q == LAST_LANE) begin
               state_d = StCommit;
            end else begin
               lane_d = lane_q + IDX_W'(1);
            end
         end

         StCommit: begin
            sel_bus_d = shadow_q;
            used_d    = cnt_q;
            fail_d    = flag_q;
            done_d    = 1'b1;
            state_d   = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign fault_ready = (state_q == StIdle);
   assign sel_bus     = sel_bus_q;
   assign remap_done  = done_q;
   assign remap_fail  = fail_q;
   assign spares_used = used_q;

endmodule

// File: tb/tb_proxy_remap_ctrl.sv
// Bench for proxy_remap_ctrl: table vectors, directed corner sequences and random maps
// checked against a prefix-count model of spare allocation.
module tb_proxy_remap_ctrl;

   localparam int unsigned NL = 4;
   localparam int unsigned NS = 2;
   localparam int unsigned SW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             fault_valid;
   logic             fault_ready;
   logic [NL-1:0]    fault_map;
   logic             clear;
   logic [NL*SW-1:0] sel_bus;
   logic             remap_done;
   logic             remap_fail;
   logic [1:0]       spares_used;

   proxy_remap_ctrl #(
      .NUM_LANES  (NL),
      .NUM_SPARES (NS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fault_valid (fault_valid),
      .fault_ready (fault_ready),
      .fault_map   (fault_map),
      .clear       (clear),
      .sel_bus     (sel_bus),
      .remap_done  (remap_done),
      .remap_fail  (remap_fail),
      .spares_used (spares_used)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_sel;
   logic [1:0] exp_used;
   logic       exp_fail;

   typedef struct {
      logic [3:0] map;
      logic [7:0] sel;
      logic [1:0] used;
      logic       fail;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Lane i takes spare n when it is the n-th faulty lane and n <= NS.
   function automatic void ref_model(input logic [3:0] m, output logic [7:0] s,
                                     output logic [1:0] u, output logic f);
      int n;
      n = 0;
      s = '0;
      for (int i = 0; i < int'(NL); i++) begin
         if (m[i]) begin
            n++;
            if (n <= int'(NS)) s[i*SW +: SW] = 2'(n);
         end
      end
      u = 2'((n > int'(NS)) ? int'(NS) : n);
      f = (n > int'(NS));
   endfunction

   task automatic chk_outputs(input string tag);
      chk({tag, "_sel"},  32'(sel_bus),     32'(exp_sel));
      chk({tag, "_used"}, 32'(spares_used), 32'(exp_used));
      chk({tag, "_fail"}, 32'(remap_fail),  32'(exp_fail));
   endtask

   // mode 0: quiet scan; 1: fault_valid pulse while busy; 2: clear pulse while busy
   task automatic run_map(input logic [3:0] map, input bit with_clear, input int mode);
      logic [7:0] s;
      logic [1:0] u;
      logic       f;
      ref_model(map, s, u, f);
      @(negedge clk);
      chk("ready_idle", 32'(fault_ready), 1);
      fault_valid = 1'b1;
      fault_map   = map;
      clear       = with_clear;
      @(posedge clk);
      #1;
      fault_valid = 1'b0;
      clear       = 1'b0;
      fault_map   = 4'($urandom);
      chk("ready_accept", 32'(fault_ready), 0);
      chk("fail_cleared", 32'(remap_fail), 0);
      chk("sel_accept", 32'(sel_bus), 32'(exp_sel));
      chk("used_accept", 32'(spares_used), 32'(exp_used));
      exp_fail = 1'b0;
      for (int k = 1; k <= int'(NL) + 1; k++) begin
         if (k == 2 && mode != 0) begin
            @(negedge clk);
            if (mode == 1) begin
               fault_valid = 1'b1;
               fault_map   = 4'($urandom);
            end else begin
               clear = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         fault_valid = 1'b0;
         clear       = 1'b0;
         if (k <= int'(NL)) begin
            chk("ready_scan", 32'(fault_ready), 0);
            chk("sel_scan", 32'(sel_bus), 32'(exp_sel));
            chk("done_scan", 32'(remap_done), 0);
         end
      end
      exp_sel  = s;
      exp_used = u;
      exp_fail = f;
      chk("done_pulse", 32'(remap_done), 1);
      chk("ready_back", 32'(fault_ready), 1);
      chk_outputs("commit");
      @(posedge clk);
      #1;
      chk("done_once", 32'(remap_done), 0);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "_nodone"}, 32'(remap_done), 0);
         chk({tag, "_ready"}, 32'(fault_ready), 1);
         chk_outputs(tag);
      end
   endtask

   task automatic do_clear(input string tag);
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      exp_sel  = '0;
      exp_used = '0;
      chk({tag, "_done"}, 32'(remap_done), 0);
      chk_outputs(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{map: 4'b0000, sel: 8'h00, used: 2'd0, fail: 1'b0};
      vecs[1] = '{map: 4'b1010, sel: 8'h84, used: 2'd2, fail: 1'b0};
      vecs[2] = '{map: 4'b1011, sel: 8'h09, used: 2'd2, fail: 1'b1};
      vecs[3] = '{map: 4'b0100, sel: 8'h10, used: 2'd1, fail: 1'b0};
      vecs[4] = '{map: 4'b0001, sel: 8'h01, used: 2'd1, fail: 1'b0};
      vecs[5] = '{map: 4'b1111, sel: 8'h09, used: 2'd2, fail: 1'b1};
      vecs[6] = '{map: 4'b1000, sel: 8'h40, used: 2'd1, fail: 1'b0};
      vecs[7] = '{map: 4'b0110, sel: 8'h24, used: 2'd2, fail: 1'b0};
      vecs[8] = '{map: 4'b1101, sel: 8'h21, used: 2'd2, fail: 1'b1};

      rst         = 1'b1;
      fault_valid = 1'b0;
      fault_map   = '0;
      clear       = 1'b0;
      exp_sel     = '0;
      exp_used    = '0;
      exp_fail    = 1'b0;
      #12;
      chk("rst_ready", 32'(fault_ready), 1);
      chk("rst_done", 32'(remap_done), 0);
      chk_outputs("rst");
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_map(vecs[i].map, 1'b0, 0);
         chk("tbl_sel", 32'(sel_bus), 32'(vecs[i].sel));
         chk("tbl_used", 32'(spares_used), 32'(vecs[i].used));
         chk("tbl_fail", 32'(remap_fail), 32'(vecs[i].fail));
      end

      // Map offered while busy must be ignored.
      run_map(4'b0100, 1'b0, 1);
      chk("busy_sel", 32'(sel_bus), 32'h10);
      idle_cycles(6, "busy_idle");

      // clear during a scan is ignored; clear with a handshake is dropped.
      run_map(4'b1010, 1'b0, 2);
      chk("clr_scan_sel", 32'(sel_bus), 32'h84);
      run_map(4'b0001, 1'b1, 0);

      // Reset in the second scan cycle.
      run_map(4'b1010, 1'b0, 0);
      @(negedge clk);
      fault_valid = 1'b1;
      fault_map   = 4'b1111;
      @(posedge clk);
      #1;
      fault_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      exp_sel  = '0;
      exp_used = '0;
      exp_fail = 1'b0;
      chk("midrst_ready", 32'(fault_ready), 1);
      chk("midrst_done", 32'(remap_done), 0);
      chk_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(8, "postrst");
      run_map(4'b1111, 1'b0, 0);

      // clear zeroes selects/count but keeps the fail flag.
      run_map(4'b1010, 1'b0, 0);
      do_clear("clr_84");
      chk("clr_84_sel", 32'(sel_bus), 0);
      run_map(4'b1111, 1'b0, 0);
      do_clear("clr_fail");
      chk("clr_fail_kept", 32'(remap_fail), 1);

      for (int it = 0; it < 40; it++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            bit c;
            c = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            clear = c;
            @(posedge clk);
            #1;
            clear = 1'b0;
            if (c) begin
               exp_sel  = '0;
               exp_used = '0;
            end
            chk("rnd_gap_done", 32'(remap_done), 0);
            chk_outputs("rnd_gap");
         end
         run_map(4'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
